fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core. It owns the PC, the IF/ID pipeline register and the request/acknowledge port to instruction memory. It is the consumer of the stall logic's `IF_ID_stall` output and of the ID-stage branch redirect. It holds, bubbles or flushes IF/ID so that no instruction is lost or duplicated under variable memory latency.

---
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_stage.sv | 158 +++++++++++++++
 tb/tb_fetch_stage.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge port between the fetch stage and imem.
// One ack per request; rdata is only meaningful in the ack cycle.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, IF/ID register, one-entry skid buffer and
// a request FSM that tolerates variable memory latency, stalls and redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          IF_ID_stall,
  input  logic          pcSrc_ID,
  input  logic [31:0]   pcBranch_ID,
  fetch_stage_if.master imem,
  output logic [31:0]   instr_ID,
  output logic [31:0]   pcPlus4_ID,
  output logic          valid_ID
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic        skid_valid_q, skid_valid_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] fetch_addr;

  // A redirect only counts when the branch instruction in ID is real and moving.
  assign redirect   = pcSrc_ID & valid_q & ~IF_ID_stall;
  assign target     = pcBranch_ID & 32'hFFFF_FFFC;
  // While draining, the abandoned request must keep its original address.
  assign fetch_addr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;

  assign imem.imem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem.imem_addr = fetch_addr;

  assign instr_ID   = instr_q;
  assign pcPlus4_ID = pc4_q;
  assign valid_ID   = valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    skid_valid_d = skid_valid_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (redirect) begin
          pc_d    = target;
          instr_d = 32'h0;
          pc4_d   = 32'h0;
          valid_d = 1'b0;
          if (!imem.imem_ack) begin
            drain_addr_d = pc_q;
            state_d      = S_DRAIN;
          end
        end else if (imem.imem_ack) begin
          pc_d = pc_q + 32'd4;
          if (!IF_ID_stall) begin
            instr_d = imem.imem_rdata;
            pc4_d   = fetch_addr + 32'd4;
            valid_d = 1'b1;
          end else begin
            skid_instr_d = imem.imem_rdata;
            skid_pc4_d   = fetch_addr + 32'd4;
            skid_valid_d = 1'b1;
            state_d      = S_HOLD;
          end
        end else if (!IF_ID_stall) begin
          instr_d = 32'h0;
          pc4_d   = 32'h0;
          valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d         = target;
          instr_d      = 32'h0;
          pc4_d        = 32'h0;
          valid_d      = 1'b0;
          skid_instr_d = 32'h0;
          skid_pc4_d   = 32'h0;
          skid_valid_d = 1'b0;
          state_d      = S_FETCH;
        end else if (!IF_ID_stall) begin
          instr_d      = skid_instr_q;
          pc4_d        = skid_pc4_q;
          valid_d      = skid_valid_q;
          skid_instr_d = 32'h0;
          skid_pc4_d   = 32'h0;
          skid_valid_d = 1'b0;
          state_d      = S_FETCH;
        end
      end

      S_DRAIN: begin
        instr_d = 32'h0;
        pc4_d   = 32'h0;
        valid_d = 1'b0;
        if (imem.imem_ack) begin
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC_ALIGNED;
      drain_addr_q <= 32'h0;
      instr_q      <= 32'h0;
      pc4_q        <= 32'h0;
      valid_q      <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc4_q   <= 32'h0;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: zero-wait streaming, stall/HOLD, latency bubbles,
// redirect with and without ack (drain), and asynchronous reset mid-request/mid-HOLD.
module tb_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        pc_src;
  logic [31:0] pc_branch;
  logic [31:0] instr_id;
  logic [31:0] pc4_id;
  logic        valid_id;

  int mem_lat;
  int wait_cnt;
  int n_checks;
  int n_pass;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC (32'h0040_0000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .IF_ID_stall (stall),
    .pcSrc_ID    (pc_src),
    .pcBranch_ID (pc_branch),
    .imem        (bus),
    .instr_ID    (instr_id),
    .pcPlus4_ID  (pc4_id),
    .valid_ID    (valid_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'hDEAD_BEEF;
  endfunction

  // Memory model: acks a request after mem_lat wait cycles, decided just after each edge.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    wait_cnt       = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n || !bus.imem_req) begin
        wait_cnt     = 0;
        bus.imem_ack = 1'b0;
      end else if (wait_cnt >= mem_lat) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
        wait_cnt       = 0;
      end else begin
        bus.imem_ack = 1'b0;
        wait_cnt     = wait_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      n_pass = n_pass + 1;
    end
  endtask

  task automatic check_id(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                          input logic ev);
    check({tag, ".instr"}, instr_id, ei);
    check({tag, ".pc4"},   pc4_id,   ep);
    check({tag, ".valid"}, {31'h0, valid_id}, {31'h0, ev});
    $display("%t %s: instr=%08h pc4=%08h valid=%0d req=%0d addr=%08h", $time, tag,
             instr_id, pc4_id, valid_id, bus.imem_req, bus.imem_addr);
  endtask

  task automatic check_bus(input string tag, input logic er, input logic [31:0] ea);
    check({tag, ".req"}, {31'h0, bus.imem_req}, {31'h0, er});
    if (er) check({tag, ".addr"}, bus.imem_addr, ea);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset_n   = 1'b0;
    stall     = 1'b0;
    pc_src    = 1'b0;
    pc_branch = 32'h0;
    mem_lat   = 0;

    repeat (3) tick();
    check_bus("rst", 1'b0, 32'h0);
    check_id("rst", 32'h0, 32'h0, 1'b0);

    // Release reset mid-cycle: IDLE first, request in the next cycle.
    reset_n = 1'b1;
    #1;
    check_bus("idle", 1'b0, 32'h0);
    tick();
    check_bus("first", 1'b1, 32'h0040_0000);
    tick();
    check_id("zw0", 32'hDEED_BEEF, 32'h0040_0004, 1'b1);
    check_bus("zw0", 1'b1, 32'h0040_0004);
    tick();
    check_id("zw1", 32'hDEED_BEEB, 32'h0040_0008, 1'b1);
    check_bus("zw1", 1'b1, 32'h0040_0008);

    // Stall for 3 cycles starting with the ack of 0x00400008.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bus("hold", 1'b0, 32'h0);
      check_id("hold", 32'hDEED_BEEB, 32'h0040_0008, 1'b1);
    end
    stall = 1'b0;
    tick();
    check_id("release", 32'hDEED_BEE7, 32'h0040_000C, 1'b1);
    check_bus("release", 1'b1, 32'h0040_000C);
    tick();
    check_id("seq", 32'hDEED_BEE3, 32'h0040_0010, 1'b1);
    check_bus("seq", 1'b1, 32'h0040_0010);

    // Redirect coinciding with the ack of 0x00400010; low target bits are dropped.
    pc_src    = 1'b1;
    pc_branch = 32'h0040_0102;
    tick();
    pc_src = 1'b0;
    check_id("redir_ack", 32'h0, 32'h0, 1'b0);
    check_bus("redir_ack", 1'b1, 32'h0040_0100);
    tick();
    check_id("target", 32'hDEED_BFEF, 32'h0040_0104, 1'b1);
    check_bus("target", 1'b1, 32'h0040_0104);

    // Two-cycle memory latency: two bubbles per instruction.
    mem_lat = 2;
    tick();
    check_id("lat2.v0", 32'hDEED_BFEB, 32'h0040_0108, 1'b1);
    check_bus("lat2.v0", 1'b1, 32'h0040_0108);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_id("lat2.b0", 32'h0, 32'h0, 1'b0);
      check_bus("lat2.b0", 1'b1, 32'h0040_0108);
    end
    tick();
    check_id("lat2.v1", 32'hDEED_BFE7, 32'h0040_010C, 1'b1);
    check_bus("lat2.v1", 1'b1, 32'h0040_010C);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_id("lat2.b1", 32'h0, 32'h0, 1'b0);
      check_bus("lat2.b1", 1'b1, 32'h0040_010C);
    end
    mem_lat = 3;
    tick();
    check_id("lat2.v2", 32'hDEED_BFE3, 32'h0040_0110, 1'b1);
    check_bus("lat2.v2", 1'b1, 32'h0040_0110);

    // Redirect while 0x00400110 is outstanding with 3-cycle latency: drain it.
    pc_src    = 1'b1;
    pc_branch = 32'h0040_0100;
    tick();
    pc_src = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_id("drain", 32'h0, 32'h0, 1'b0);
      check_bus("drain", 1'b1, 32'h0040_0110);
      tick();
    end
    check_id("drained", 32'h0, 32'h0, 1'b0);
    check_bus("drained", 1'b1, 32'h0040_0100);
    mem_lat = 0;
    tick();
    check_id("post_drain", 32'h0, 32'h0, 1'b0);
    tick();
    check_id("post_drain.v", 32'hDEED_BFEF, 32'h0040_0104, 1'b1);

    // Asynchronous reset while a request is outstanding.
    reset_n = 1'b0;
    #1;
    check_bus("rst_req", 1'b0, 32'h0);
    check_id("rst_req", 32'h0, 32'h0, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    check_bus("restart", 1'b1, 32'h0040_0000);
    tick();
    check_id("restart", 32'hDEED_BEEF, 32'h0040_0004, 1'b1);

    // Asynchronous reset while in HOLD; skid must not survive.
    stall = 1'b1;
    tick();
    check_bus("hold2", 1'b0, 32'h0);
    check_id("hold2", 32'hDEED_BEEF, 32'h0040_0004, 1'b1);
    reset_n = 1'b0;
    #1;
    check_bus("rst_hold", 1'b0, 32'h0);
    check_id("rst_hold", 32'h0, 32'h0, 1'b0);
    stall = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check_bus("restart2", 1'b1, 32'h0040_0000);
    tick();
    check_id("restart2", 32'hDEED_BEEF, 32'h0040_0004, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
